// File: rtl/fir_shift_add_mac.sv
// Time-multiplexed shift/add FIR tap engine: one sample in, NTAPS weighted taps summed one per cycle.
// Latency: sample accepted at edge T -> out_valid sampled high at edge T+NTAPS+1; one sample per NTAPS+2 cycles best case.
// Backpressure: in_ready low outside IDLE; result held in OUT until out_ready. Optional FIR_SAT_EN saturates the accumulator.
module fir_shift_add_mac #(
  parameter int NTAPS = 8,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data,
  input  logic            coef_we,
  input  logic [IDXW-1:0] coef_addr,
  input  logic [5:0]      coef_data,
  output logic            coef_err
);

  localparam int DEPTH = 1 << IDXW;
  localparam logic [IDXW:0]   NT   = (IDXW+1)'(NTAPS);
  localparam logic [IDXW-1:0] LAST = IDXW'(NTAPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t          state;
  logic [15:0]     x    [DEPTH];
  logic [5:0]      coef [DEPTH];
  logic [15:0]     acc;
  logic [IDXW-1:0] idx;

  logic [5:0]  c;
  logic [15:0] shifted, term, sum, acc_next;
  logic        coef_ok;

  // 16-bit Kogge-Stone parallel-prefix adder, the single accumulation adder
  function automatic logic [15:0] ppa_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g, p, gn, pn;
    g = a & b;
    p = a ^ b;
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 16; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return (a ^ b) ^ {g[14:0], 1'b0};
  endfunction

  always_comb begin
    c        = coef[idx];
    shifted  = $unsigned($signed(x[idx]) >>> c[3:0]);
    term     = 16'd0;
    if (c[5]) term = c[4] ? (16'd0 - shifted) : shifted;
    sum      = ppa_add(acc, term);
    acc_next = sum;
`ifdef FIR_SAT_EN
    if ((acc[15] == term[15]) && (sum[15] != acc[15]))
      acc_next = acc[15] ? 16'h8000 : 16'h7fff;
`endif
  end

  assign coef_ok  = (state != S_ACCUM) && ({1'b0, coef_addr} < NT);
  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= 16'd0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'd0;
      coef_err  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        x[k]    <= 16'd0;
        coef[k] <= 6'd0;
      end
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_we && coef_ok) coef[coef_addr] <= coef_data;

      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = 1; k < NTAPS; k++) x[k] <= x[k-1];
            x[0]  <= in_data;
            acc   <= 16'd0;
            idx   <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_shift_add_mac.sv
// Directed + random bench for fir_shift_add_mac; expected results come from an integer reference model.
module tb_fir_shift_add_mac;
  localparam int NTAPS = 8;
  localparam int IDXW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            coef_we;
  logic [IDXW-1:0] coef_addr;
  logic [5:0]      coef_data;
  logic            coef_err;

  always #5 clk = ~clk;

  fir_shift_add_mac #(.NTAPS(NTAPS), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err)
  );

  int          checks = 0;
  int          failures = 0;
  logic [15:0] sb[$];
  int          m_x[NTAPS];
  logic [5:0]  m_c[NTAPS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      m_x[k] = 0;
      m_c[k] = 6'd0;
    end
  endfunction

  function automatic void model_shift(input logic [15:0] d);
    for (int k = NTAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = int'($signed(d));
  endfunction

  function automatic logic [15:0] model_eval();
    int acc;
    int v;
    int t;
    acc = 0;
    for (int k = 0; k < NTAPS; k++) begin
      v = m_x[k] >>> m_c[k][3:0];
      t = 0;
      if (m_c[k][5]) t = m_c[k][4] ? -v : v;
      t = int'($signed(t[15:0]));
      acc = acc + t;
`ifdef FIR_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`else
      acc = int'($signed(acc[15:0]));
`endif
    end
    return acc[15:0];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb.delete();
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("send_ready", in_ready, 1);
    @(posedge clk);
    model_shift(d);
    sb.push_back(model_eval());
    #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] got);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("recv_valid", out_valid, 1);
    got = out_data;
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) check("scoreboard", out_data, sb.pop_front());
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic wcoef(input logic [IDXW-1:0] a, input logic [5:0] d, input logic exp_err);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    check("coef_err", coef_err, exp_err);
    if (!exp_err) m_c[a] = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [15:0] imp_exp[8];
    int n;

    rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = 6'd0;

    // 1: reset values, latency, in_ready low while busy
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_coef_err", coef_err, 0);
    send(16'h1234);
    check("busy_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (!out_valid) check("accum_in_ready", in_ready, 0);
    end
    // out_valid registers at edge T+NTAPS, so it is sampled high at edge T+NTAPS+1
    check("latency_edges", n, NTAPS);
    check("out_in_ready", in_ready, 0);
    recv(got);
    check("default_coef_out", got, 16'h0000);

    // 2: impulse response with a positive and a negated/shifted tap
    do_reset();
    wcoef(0, 6'h20, 0);
    wcoef(3, 6'h31, 0);
    imp_exp[0] = 16'h0100; imp_exp[1] = 16'h0000; imp_exp[2] = 16'h0000; imp_exp[3] = 16'hff80;
    imp_exp[4] = 16'h0000; imp_exp[5] = 16'h0000; imp_exp[6] = 16'h0000; imp_exp[7] = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      send(i == 0 ? 16'h0100 : 16'h0000);
      recv(got);
      check($sformatf("impulse_%0d", i), got, imp_exp[i]);
    end

    // 3: output held under backpressure, input ignored
    send(16'haaaa);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b1;
    in_data  = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, sb[0]);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    got = sb.pop_front();
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_data_kept", out_data, got);
    send(16'h5555);
    recv(got);

    // 4: overflow behaviour
    do_reset();
    wcoef(0, 6'h20, 0);
    wcoef(1, 6'h20, 0);
    send(16'h7000);
    recv(got);
    check("ovf_first", got, 16'h7000);
    send(16'h7000);
    recv(got);
`ifdef FIR_SAT_EN
    check("ovf_second", got, 16'h7fff);
`else
    check("ovf_second", got, 16'he000);
`endif

    // 5: rejected coefficient writes
    send(16'h4000);
    wcoef(2, 6'h20, 1);
    @(posedge clk);
    #1;
    check("err_pulse_end", coef_err, 0);
    recv(got);
    wcoef(9, 6'h20, 1);
    @(posedge clk);
    #1;
    check("err_addr_pulse_end", coef_err, 0);
    send(16'h0123);
    recv(got);

    // random coefficients and samples
    for (int i = 0; i < NTAPS; i++) wcoef(IDXW'(i), 6'($urandom_range(0, 63)), 0);
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom));
      recv(got);
    end

    // 6: reset mid-accumulation
    wcoef(0, 6'h20, 0);
    send(16'h1111);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    sb.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    wcoef(0, 6'h20, 0);
    send(16'h2345);
    recv(got);
    check("midrst_sample", got, 16'h2345);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
